// File: rtl/spart_pkg.sv
// Shared types and baud divisor table for the SPART bus driver.
// Divisors assume a 50 MHz system clock.
package spart_pkg;

   typedef enum logic [1:0] {
      ADDR_BUF  = 2'b00,
      ADDR_STAT = 2'b01,
      ADDR_DBL  = 2'b10,
      ADDR_DBH  = 2'b11
   } ioaddr_t;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      RD,
      WR,
      TURN
   } drv_state_t;

   localparam logic [15:0] DIV_4800  = 16'h28B0;
   localparam logic [15:0] DIV_9600  = 16'h1458;
   localparam logic [15:0] DIV_19200 = 16'h0A2C;
   localparam logic [15:0] DIV_38400 = 16'h0516;

   function automatic logic [15:0] div_of(input logic [1:0] sel);
      logic [15:0] d;
      case (sel)
         2'b00:   d = DIV_4800;
         2'b01:   d = DIV_9600;
         2'b10:   d = DIV_19200;
         default: d = DIV_38400;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/spart_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; push and pop are never simultaneous
// in this design, but each is independently guarded against full/empty.
module spart_byte_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop && !empty)
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/spart_driver.sv
// Bus-side SPART controller: programs the baud divisor, then services
// receive reads and round-robin echo/host transmit writes.
module spart_driver
   import spart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter bit ECHO_EN    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   input  logic       rda,
   input  logic       tbr,
   input  logic       host_tx_valid,
   input  logic [7:0] host_tx_data,
   output logic       host_tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       cfg_done
);

   drv_state_t  state, state_nxt;
   drv_state_t  ret_state, ret_nxt;
   ioaddr_t     addr_sel;
   logic        started;
   logic [1:0]  cfg_sel;
   logic        cfg_turn;
   logic        last_host;
   logic        grant_host, grant_nxt;
   logic [7:0]  wdata;
   logic [15:0] div_val;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
   logic        echo_ok, host_ok;

   assign div_val = div_of(cfg_sel);
   assign echo_ok = !fifo_empty;
   assign host_ok = host_tx_valid;

   spart_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (databus),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CFG_LO;
         ret_state <= CFG_HI;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_nxt;
      end
   end

   // The first cycle after reset holds CFG_LO with the bus idle (started=0).
   always_comb begin
      state_nxt     = state;
      ret_nxt       = ret_state;
      grant_nxt     = grant_host;
      iocs          = 1'b0;
      iorw          = 1'b1;
      addr_sel      = ADDR_BUF;
      wdata         = 8'h00;
      host_tx_ready = 1'b0;
      fifo_push     = 1'b0;
      fifo_pop      = 1'b0;
      case (state)
         CFG_LO: begin
            if (started) begin
               iocs      = 1'b1;
               iorw      = 1'b0;
               addr_sel  = ADDR_DBL;
               wdata     = div_val[7:0];
               state_nxt = TURN;
               ret_nxt   = CFG_HI;
            end
         end
         CFG_HI: begin
            iocs      = 1'b1;
            iorw      = 1'b0;
            addr_sel  = ADDR_DBH;
            wdata     = div_val[15:8];
            state_nxt = TURN;
            ret_nxt   = IDLE;
         end
         IDLE: begin
            if (br_cfg != cfg_sel) begin
               state_nxt = CFG_LO;
            end else if (rda && !fifo_full) begin
               state_nxt = RD;
            end else if (tbr && (echo_ok || host_ok)) begin
               state_nxt = WR;
               grant_nxt = host_ok && (!echo_ok || !last_host);
            end
         end
         RD: begin
            iocs      = 1'b1;
            fifo_push = ECHO_EN;
            state_nxt = TURN;
            ret_nxt   = IDLE;
         end
         WR: begin
            iocs          = 1'b1;
            iorw          = 1'b0;
            wdata         = grant_host ? host_tx_data : fifo_dout;
            host_tx_ready = grant_host;
            fifo_pop      = !grant_host;
            state_nxt     = TURN;
            ret_nxt       = IDLE;
         end
         TURN:    state_nxt = ret_state;
         default: state_nxt = CFG_LO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         started    <= 1'b0;
         cfg_sel    <= br_cfg;
         cfg_turn   <= 1'b0;
         cfg_done   <= 1'b0;
         last_host  <= 1'b1;
         grant_host <= 1'b0;
         rx_valid   <= 1'b0;
         rx_data    <= 8'h00;
      end else begin
         started    <= 1'b1;
         grant_host <= grant_nxt;
         rx_valid   <= (state == RD);
         if (state == RD)
            rx_data <= databus;
         if (state == WR)
            last_host <= grant_host;
         if (state == IDLE && br_cfg != cfg_sel) begin
            cfg_sel  <= br_cfg;
            cfg_done <= 1'b0;
         end
         if (state == CFG_HI)
            cfg_turn <= 1'b1;
         if (state == TURN && cfg_turn) begin
            cfg_done <= 1'b1;
            cfg_turn <= 1'b0;
         end
      end
   end

   assign ioaddr  = addr_sel;
   assign databus = (iocs && !iorw) ? wdata : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: SPART and host models, bus access log, directed
// sequences, a baud-table loop and a randomized echo/host traffic phase.
module tb_spart_driver;

   logic       clk;
   logic       rst;
   logic [1:0] br_cfg;
   logic       iocs, iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       rda, tbr;
   logic       host_tx_valid;
   logic [7:0] host_tx_data;
   logic       host_tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       cfg_done;

   spart_driver dut (
      .clk           (clk),
      .rst           (rst),
      .br_cfg        (br_cfg),
      .iocs          (iocs),
      .iorw          (iorw),
      .ioaddr        (ioaddr),
      .databus       (databus),
      .rda           (rda),
      .tbr           (tbr),
      .host_tx_valid (host_tx_valid),
      .host_tx_data  (host_tx_data),
      .host_tx_ready (host_tx_ready),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .cfg_done      (cfg_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SPART receive side and host requester, both as simple byte queues
   logic [7:0] rx_mem [1024];
   logic [9:0] rx_wr = '0;
   logic [9:0] rx_rd = '0;
   logic [7:0] hq [1024];
   logic [9:0] hwr = '0;
   logic [9:0] hrd = '0;
   logic [7:0] spart_byte;

   assign rda           = (rx_wr != rx_rd);
   assign spart_byte    = rx_mem[rx_rd];
   assign databus       = (iocs && iorw) ? spart_byte : 8'hzz;
   assign host_tx_valid = (hwr != hrd);
   assign host_tx_data  = hq[hrd];

   always @(posedge clk) begin
      if (iocs && iorw && ioaddr == 2'b00)
         rx_rd <= rx_rd + 10'd1;
      if (host_tx_ready)
         hrd <= hrd + 10'd1;
   end

   // Bus/upstream monitor: {addr, rw, data} per access, received bytes,
   // back-to-back access count, echo FIFO occupancy high-water mark.
   logic [10:0] acc_q [$];
   logic [7:0]  rxl [$];
   int          b2b = 0;
   int          occ = 0;
   int          occ_max = 0;
   int          hr_cnt = 0;
   logic        prev_iocs = 1'b0;

   always @(negedge clk) begin
      if (iocs) begin
         if (prev_iocs)
            b2b = b2b + 1;
         acc_q.push_back({ioaddr, iorw, databus});
         if (iorw && ioaddr == 2'b00)
            occ = occ + 1;
         else if (!iorw && ioaddr == 2'b00 && !host_tx_ready)
            occ = occ - 1;
         if (occ > occ_max)
            occ_max = occ;
      end
      if (host_tx_ready)
         hr_cnt = hr_cnt + 1;
      if (rx_valid)
         rxl.push_back(rx_data);
      if (rst)
         occ = 0;
      prev_iocs = iocs;
   end

   int tests = 0;
   int fails = 0;
   int acc_rd = 0;
   int rxl_rd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_acc(input string name, input logic [10:0] exp);
      int c;
      c = 0;
      while (acc_q.size() <= acc_rd && c < 40) begin
         @(negedge clk);
         c++;
      end
      if (acc_q.size() > acc_rd) begin
         chk(name, {21'd0, acc_q[acc_rd]}, {21'd0, exp});
         acc_rd++;
      end else begin
         tests = tests + 1;
         fails = fails + 1;
         $display("FAIL %s: no bus access within 40 cycles, expected %0h", name, exp);
      end
   endtask

   task automatic expect_rx(input string name, input logic [7:0] exp);
      int c;
      c = 0;
      while (rxl.size() <= rxl_rd && c < 20) begin
         @(negedge clk);
         c++;
      end
      if (rxl.size() > rxl_rd) begin
         chk(name, {24'd0, rxl[rxl_rd]}, {24'd0, exp});
         rxl_rd++;
      end else begin
         tests = tests + 1;
         fails = fails + 1;
         $display("FAIL %s: no rx_valid within 20 cycles, expected %0h", name, exp);
      end
   endtask

   task automatic wait_cfg(input string name);
      int c;
      c = 0;
      while (!cfg_done && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk(name, {31'd0, cfg_done}, 32'd1);
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_mem[rx_wr] = b;
      rx_wr = rx_wr + 10'd1;
   endtask

   task automatic push_host(input logic [7:0] b);
      hq[hwr] = b;
      hwr = hwr + 10'd1;
   endtask

   typedef struct {
      logic [1:0] sel;
      logic [7:0] lo;
      logic [7:0] hi;
   } cfg_vec_t;

   cfg_vec_t   vec [4];
   logic [7:0] exp_rx [$];
   logic [7:0] exp_host [$];
   logic [7:0] got_rd [$];
   logic [7:0] got_echo [$];
   logic [7:0] got_host [$];

   initial begin
      int hr0, a0, r0, c;
      logic [10:0] e;

      vec[0] = '{2'b11, 8'h16, 8'h05};
      vec[1] = '{2'b00, 8'hB0, 8'h28};
      vec[2] = '{2'b10, 8'h2C, 8'h0A};
      vec[3] = '{2'b01, 8'h58, 8'h14};

      rst = 1'b1;
      br_cfg = 2'b01;
      tbr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_iocs", {31'd0, iocs}, 32'd0);
      chk("rst_iorw", {31'd0, iorw}, 32'd1);
      chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_host_ready", {31'd0, host_tx_ready}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      rst = 1'b0;

      expect_acc("cfg_lo_9600", {2'b10, 1'b0, 8'h58});
      expect_acc("cfg_hi_9600", {2'b11, 1'b0, 8'h14});
      wait_cfg("cfg_done_rise");

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         br_cfg = vec[i].sel;
         @(negedge clk);
         chk("cfg_drop", {31'd0, cfg_done}, 32'd0);
         expect_acc("tbl_cfg_lo", {2'b10, 1'b0, vec[i].lo});
         expect_acc("tbl_cfg_hi", {2'b11, 1'b0, vec[i].hi});
         wait_cfg("tbl_cfg_done");
      end

      // single received byte is read, reported, then echoed
      tbr = 1'b1;
      push_rx(8'hA5);
      expect_acc("echo_rd", {2'b00, 1'b1, 8'hA5});
      expect_acc("echo_wr", {2'b00, 1'b0, 8'hA5});
      expect_rx("echo_rx", 8'hA5);

      // host alone, so the last grant becomes host
      hr0 = hr_cnt;
      push_host(8'h77);
      expect_acc("host_only_wr", {2'b00, 1'b0, 8'h77});
      repeat (3) @(negedge clk);
      chk("host_only_ready", hr_cnt - hr0, 32'd1);

      // both eligible: echo wins after a host grant
      tbr = 1'b0;
      push_rx(8'h11);
      expect_acc("arb_rd", {2'b00, 1'b1, 8'h11});
      expect_rx("arb_rx", 8'h11);
      hr0 = hr_cnt;
      push_host(8'h3C);
      repeat (2) @(negedge clk);
      tbr = 1'b1;
      expect_acc("arb_wr_echo", {2'b00, 1'b0, 8'h11});
      expect_acc("arb_wr_host", {2'b00, 1'b0, 8'h3C});
      repeat (4) @(negedge clk);
      chk("arb_ready_once", hr_cnt - hr0, 32'd1);

      // FIFO full: fifth byte stays in the SPART until a WR frees space
      tbr = 1'b0;
      for (int i = 1; i <= 5; i++) push_rx(8'(i));
      for (int i = 1; i <= 4; i++) expect_acc("full_rd", {2'b00, 1'b1, 8'(i)});
      repeat (12) @(negedge clk);
      chk("full_no_rd", acc_q.size() - acc_rd, 32'd0);
      chk("full_rda_held", {31'd0, rda}, 32'd1);
      tbr = 1'b1;
      expect_acc("full_wr1", {2'b00, 1'b0, 8'h01});
      expect_acc("full_rd5", {2'b00, 1'b1, 8'h05});
      for (int i = 2; i <= 5; i++) expect_acc("full_wr", {2'b00, 1'b0, 8'(i)});
      for (int i = 1; i <= 5; i++) expect_rx("full_rx_order", 8'(i));

      // reset in the middle of a WR with one more byte still queued
      tbr = 1'b0;
      push_rx(8'h21);
      push_rx(8'h22);
      expect_acc("rst_pre_rd1", {2'b00, 1'b1, 8'h21});
      expect_acc("rst_pre_rd2", {2'b00, 1'b1, 8'h22});
      expect_rx("rst_pre_rx1", 8'h21);
      expect_rx("rst_pre_rx2", 8'h22);
      tbr = 1'b1;
      c = 0;
      @(negedge clk);
      while (!(iocs && !iorw) && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("rst_found_wr", {31'd0, iocs && !iorw}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      acc_rd = acc_q.size();
      chk("rst_mid_iocs", {31'd0, iocs}, 32'd0);
      chk("rst_mid_cfg_done", {31'd0, cfg_done}, 32'd0);
      rst = 1'b0;
      expect_acc("rst_cfg_lo", {2'b10, 1'b0, 8'h58});
      expect_acc("rst_cfg_hi", {2'b11, 1'b0, 8'h14});
      wait_cfg("rst_cfg_done");
      repeat (20) @(negedge clk);
      chk("rst_fifo_flushed", acc_q.size() - acc_rd, 32'd0);

      // randomized traffic: rx bytes have MSB 0, host bytes MSB 1
      a0 = acc_q.size();
      r0 = rxl.size();
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0 && exp_rx.size() < 80) begin
            e[7:0] = 8'($urandom_range(0, 127));
            push_rx(e[7:0]);
            exp_rx.push_back(e[7:0]);
         end
         if ($urandom_range(0, 11) == 0 && exp_host.size() < 60) begin
            e[7:0] = 8'($urandom_range(128, 255));
            push_host(e[7:0]);
            exp_host.push_back(e[7:0]);
         end
         tbr = ($urandom_range(0, 3) != 0);
      end
      tbr = 1'b1;
      repeat (500) @(negedge clk);

      for (int i = a0; i < acc_q.size(); i++) begin
         e = acc_q[i];
         if (e[8])
            got_rd.push_back(e[7:0]);
         else if (e[7])
            got_host.push_back(e[7:0]);
         else
            got_echo.push_back(e[7:0]);
      end
      chk("rand_rd_count", got_rd.size(), exp_rx.size());
      chk("rand_echo_count", got_echo.size(), exp_rx.size());
      chk("rand_host_count", got_host.size(), exp_host.size());
      chk("rand_rxv_count", rxl.size() - r0, exp_rx.size());
      for (int i = 0; i < exp_rx.size(); i++) begin
         if (i < got_rd.size())   chk("rand_rd_byte", {24'd0, got_rd[i]}, {24'd0, exp_rx[i]});
         if (i < got_echo.size()) chk("rand_echo_byte", {24'd0, got_echo[i]}, {24'd0, exp_rx[i]});
         if (r0 + i < rxl.size()) chk("rand_rxv_byte", {24'd0, rxl[r0 + i]}, {24'd0, exp_rx[i]});
      end
      for (int i = 0; i < exp_host.size() && i < got_host.size(); i++)
         chk("rand_host_byte", {24'd0, got_host[i]}, {24'd0, exp_host[i]});

      chk("no_back_to_back", b2b, 32'd0);
      chk("fifo_high_water", occ_max, 32'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus-side controller that configures and sequences one SPART over its 8-bit bidirectional I/O bus.
- After reset it programs the baud divisor from a 2-bit rate select, then services the SPART forever:
  - reads received bytes into a 4-entry echo FIFO and reports them upstream;
  - writes bytes to the SPART transmit buffer from either the echo FIFO or a local host requester, arbitrated round-robin.
- Sits between the board top level (switches, host logic) and the spart instance.

Parameters:
- FIFO_DEPTH, 4, echo FIFO entries; must be a power of two, minimum 2.
- ECHO_EN, 1, 1 = received bytes are queued for retransmission; 0 = FIFO is never written.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous reset, active-high.
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- iocs  output  1  SPART chip select; high only during a bus access cycle.
- iorw  output  1  1 = read (SPART drives databus), 0 = write (driver drives).
- ioaddr  output  2  00 tx/rx buffer, 01 status, 10 divisor low, 11 divisor high.
- databus  inout  8  shared bus; driven by this block only when iocs=1 and iorw=0, else Z.
- rda  input  1  SPART receive data available.
- tbr  input  1  SPART transmit buffer ready.
- host_tx_valid  input  1  host byte request.
- host_tx_data  input  8  host byte.
- host_tx_ready  output  1  one-cycle pulse: host byte accepted this cycle.
- rx_valid  output  1  one-cycle pulse with each received byte.
- rx_data  output  8  received byte; holds its value until the next rx_valid.
- cfg_done  output  1  high once the divisor has been programmed.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=CFG_LO; iocs=0; iorw=1; ioaddr=00; databus=Z.
  - host_tx_ready=0, rx_valid=0, rx_data=0, cfg_done=0.
  - FIFO empty (rd/wr pointers=0); arbiter last-grant=host, so echo wins the first tie.
  - Reset mid-access: aborts the access; bus released the same edge.
- Divisor constants for a 50 MHz clock, in the package: 4800=0x28B0, 9600=0x1458, 19200=0x0A2C, 38400=0x0516.
- Every bus access lasts exactly one cycle with iocs=1 and is followed by one TURN cycle with iocs=0, so the flopped rda/tbr can update. No back-to-back accesses.
- State machine: CFG_LO -> TURN -> CFG_HI -> TURN -> IDLE; IDLE -> RD | WR | CFG_LO; RD -> TURN -> IDLE; WR -> TURN -> IDLE.
- CFG_LO: write divisor[7:0] to ioaddr 10.
- CFG_HI: write divisor[15:8] to ioaddr 11. cfg_done rises on the edge leaving the CFG_HI turn cycle.
- br_cfg is sampled into cfg_sel when entering CFG_LO.
- IDLE priorities, evaluated each cycle, first match wins:
  - (1) br_cfg != cfg_sel -> CFG_LO. cfg_done drops, and an in-flight WR is not started.
  - (2) rda=1 and FIFO not full -> RD.
  - (3) tbr=1 and a requester is eligible -> WR.
  - Otherwise stay in IDLE.
- Eligibility:
  - echo eligible when the FIFO is not empty;
  - host eligible when host_tx_valid=1.
  - If both are eligible, grant the one not granted last; update last-grant on every WR.
- RD: iorw=1, ioaddr=00. The databus value is captured into rx_data at the end of the cycle. rx_valid pulses the following cycle (the TURN cycle). If ECHO_EN=1, the byte is pushed into the FIFO in the same cycle.
- FIFO full with rda=1: RD is withheld, leaving the byte in the SPART, until a WR drains one entry. The host never deadlocks this because an echo grant eventually frees space.
- WR: iorw=0, ioaddr=00, databus=selected byte.
  - Echo grant: FIFO pops in the same cycle.
  - Host grant: host_tx_ready pulses in the same cycle. The host must hold data until it sees the pulse.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally. full = MSBs differ and LSBs equal; empty = all bits equal. Push and pop never occur in the same cycle, because RD and WR are exclusive.
- The status register (ioaddr 01) is not read; rda and tbr are used directly as pins.

Decomposition:
- Package spart_pkg:
  - typedef ioaddr_t enum {ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11};
  - typedef drv_state_t {CFG_LO, CFG_HI, IDLE, RD, WR, TURN}, plus a ret-state register so TURN knows where to return;
  - localparam divisor table DIV_4800..DIV_38400 and a function div_of(br_cfg).
- Sub-module: spart_byte_fifo (FIFO_DEPTH x 8, push/pop/full/empty), instantiated once.

Test Plan:
- Reset with br_cfg=01 -> writes 0x58 on ioaddr 10, then 0x14 on ioaddr 11, each iocs pulse 1 cycle with an idle cycle between; cfg_done=1 after 4 cycles; databus Z otherwise.
- Change br_cfg to 11 while idle -> cfg_done drops; reprogramming writes 0x16 then 0x05; no RD/WR is interleaved.
- Model drives 0xA5 with rda=1, tbr=1 -> RD at ioaddr 00, iorw=1; rx_valid pulses with rx_data=0xA5; next access is WR of 0xA5.
- host_tx_valid=1 with 0x3C while the FIFO holds 0x11 and tbr stays 1 -> WR order: 0x11 (echo), 0x3C (host); host_tx_ready pulses exactly once.
- tbr=0, five bytes arrive -> four RD accesses; fifth rda held without RD; raising tbr -> WR 1st byte, then RD 5th byte; nothing lost and order preserved.
- Assert rst during a WR cycle -> iocs=0 and databus=Z the next cycle; FIFO empty; configuration sequence restarts.
